icache_line_fill: RTL and testbench
===================================

// Module: icache_line_fill
// PURPOSE
//  Line-fill engine directly upstream of mp_icache_data_array (16 x 256b, byte-masked, 1RW SRAM).
//  On an I-cache miss it issues one burst read to memory and collects 4 x 64b beats into a 256b line.
//  It then writes the line into the data array with a single full-mask SRAM write and acks the cache controller.
// PARAMETERS
//  ADDR_WIDTH    32   byte address width
//  BEAT_WIDTH    64   memory beat width
//  BURST_BEATS   4    beats per line; LINE_WIDTH = BEAT_WIDTH*BURST_BEATS = 256
//  SET_IDX_WIDTH 4    data array address width; set index = addr[8:5]
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  fill_req     in   1    miss request; sampled only in IDLE
//  fill_addr    in   32   miss byte address
//  fill_ack     out  1    1-cycle pulse: line committed to data array
//  fill_line    out  256  assembled line register (valid when fill_ack=1)
//  bmem_addr    out  32   line-aligned burst address (fill_addr & ~32'h1F)
//  bmem_read    out  1    burst read request; held until bmem_ready
//  bmem_ready   in   1    request accepted this cycle
//  bmem_rdata   in   64   beat data, beat 0 = line bits [63:0]
//  bmem_rvalid  in   1    beat valid
//  data_csb0    out  1    SRAM chip select, active low
//  data_web0    out  1    SRAM write enable, active low
//  data_wmask0  out  32   SRAM byte mask
//  data_addr0   out  4    SRAM set index
//  data_din0    out  256  SRAM write data (= fill_line)
//  byp_valid    out  1    early-restart word valid (see CONFIGURATION)
//  byp_rdata    out  32   early-restart instruction word
// BEHAVIOUR
//  Reset: state IDLE, beat_cnt=0, line/addr regs=0; fill_ack=0, bmem_read=0, data_csb0=1, data_web0=1,
//   data_wmask0=0, byp_valid=0, byp_rdata=0. Reset in any state aborts: no SRAM write, no ack.
//  FSM (fill_state_t): IDLE -> REQ -> COLLECT -> WRITE -> DONE -> IDLE.
//  IDLE: fill_req=1 latches fill_addr (aligned copy -> bmem_addr, addr[8:5] -> data_addr0); go REQ.
//  REQ: bmem_read=1; bmem_ready=1 -> COLLECT (beat_cnt=0).
//  COLLECT: each bmem_rvalid writes line[beat_cnt*64 +: 64], beat_cnt++; gaps allowed;
//   on 4th beat -> WRITE. bmem_rvalid in IDLE/REQ/WRITE/DONE is ignored (memory contract: no early beats).
//  WRITE (1 cycle): data_csb0=0, data_web0=0, data_wmask0=32'hFFFF_FFFF, data_din0=line.
//   SRAM registers at the closing posedge and commits at the following negedge.
//  DONE (1 cycle): fill_ack=1, SRAM deselected; a controller read issued from the next cycle sees new data.
//  fill_req outside IDLE is ignored; back-to-back fills accepted from IDLE on the cycle after DONE.
//  Min latency: fill_req (cycle 0) -> fill_ack (cycle 7), with bmem_ready in cycle 1 and beats in cycles 2-5.
//  beat_cnt is 2 bits, wraps to 0 on the final beat; never overruns the line.
// CONFIGURATION
//  ICACHE_FILL_BYPASS_EN defined: byp_valid pulses 1 cycle after the beat with index fill_addr[4:3] arrives;
//   byp_rdata = that beat's word selected by fill_addr[2] (1 -> [63:32]). Exactly one pulse per fill.
//  Undefined: byp_valid=0, byp_rdata=0 constantly; ports remain for a stable interface.
// STRUCTURE
//  icache_pkg: fill_state_t enum, LINE_WIDTH, BEAT_WIDTH, BURST_BEATS, OFFSET_WIDTH=5, WMASK_ALL.
//  Sub-module icache_fill_line_buf: beat counter + 256b line register + last-beat flag; FSM stays in top.
// TESTING
//  Reset 2 cycles -> data_csb0=1, data_web0=1, bmem_read=0, fill_ack=0, byp_valid=0.
//  fill_addr=32'h0000_1234, ready in cycle 1, beats 64'h1111..1,2222..2,3333..3,4444..4 back-to-back ->
//   bmem_addr=32'h0000_1220, one WRITE cycle with data_addr0=4'h1, wmask all ones, din0={4444,3333,2222,1111}; fill_ack at cycle 7.
//  bmem_ready delayed 3 cycles, 2-cycle gaps between beats -> bmem_read held until ready, same line written, one ack.
//  rst asserted after 2 beats -> IDLE next cycle, no csb0 low, no ack; following fill completes with correct line.
//  fill_req held high through a fill -> second fill starts only from IDLE after DONE; exactly 2 bursts, 2 acks.
//  ICACHE_FILL_BYPASS_EN, fill_addr=32'h0000_1234 -> byp_valid 1 cycle after beat 2, byp_rdata=beat2[63:32].

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache line-fill engine.
package icache_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int BEAT_WIDTH    = 64;
    localparam int BURST_BEATS   = 4;
    localparam int LINE_WIDTH    = BEAT_WIDTH * BURST_BEATS;
    localparam int SET_IDX_WIDTH = 4;
    localparam int OFFSET_WIDTH  = 5;
    localparam int CNT_WIDTH     = $clog2(BURST_BEATS);
    localparam int WORD_WIDTH    = 32;
    localparam int WMASK_WIDTH   = LINE_WIDTH / 8;

    localparam logic [WMASK_WIDTH-1:0] WMASK_ALL = '1;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_REQ,
        FILL_COLLECT,
        FILL_WRITE,
        FILL_DONE
    } fill_state_t;

endpackage

// File: rtl/icache_fill_line_buf.sv
// Beat counter and line register: packs incoming memory beats into one cache line.
module icache_fill_line_buf
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  beat_valid_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    output logic [LINE_WIDTH-1:0] line_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o,
    output logic                  last_beat_o
);

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            line_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    // The counter wraps to zero on the final beat, so it can never index past the line.
    assign last_beat_o = beat_valid_i && !start_i && (cnt_q == CNT_WIDTH'(BURST_BEATS - 1));
    assign line_o      = line_q;
    assign beat_cnt_o  = cnt_q;

endmodule

// File: rtl/icache_line_fill.sv
// I-cache line-fill engine: burst read, line assembly, single full-mask SRAM write, ack.
// Optional early-restart word output enabled by defining ICACHE_FILL_BYPASS_EN.
module icache_line_fill
    import icache_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill_req,
    input  logic [ADDR_WIDTH-1:0]    fill_addr,
    output logic                     fill_ack,
    output logic [LINE_WIDTH-1:0]    fill_line,
    output logic [ADDR_WIDTH-1:0]    bmem_addr,
    output logic                     bmem_read,
    input  logic                     bmem_ready,
    input  logic [BEAT_WIDTH-1:0]    bmem_rdata,
    input  logic                     bmem_rvalid,
    output logic                     data_csb0,
    output logic                     data_web0,
    output logic [WMASK_WIDTH-1:0]   data_wmask0,
    output logic [SET_IDX_WIDTH-1:0] data_addr0,
    output logic [LINE_WIDTH-1:0]    data_din0,
    output logic                     byp_valid,
    output logic [WORD_WIDTH-1:0]    byp_rdata
);

    fill_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:OFFSET_WIDTH] line_addr_q, line_addr_d;
    logic                             accept;
    logic                             buf_start;
    logic                             beat_we;
    logic                             last_beat;
    logic [CNT_WIDTH-1:0]             beat_cnt;

    assign accept = (state_q == FILL_IDLE) && fill_req;

    always_comb begin
        state_d     = state_q;
        bmem_read   = 1'b0;
        fill_ack    = 1'b0;
        data_csb0   = 1'b1;
        data_web0   = 1'b1;
        data_wmask0 = '0;
        buf_start   = 1'b0;
        beat_we     = 1'b0;
        case (state_q)
            FILL_IDLE: begin
                if (fill_req) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    buf_start = 1'b1;
                    state_d   = FILL_COLLECT;
                end
            end
            FILL_COLLECT: begin
                beat_we = bmem_rvalid;
                if (last_beat) state_d = FILL_WRITE;
            end
            FILL_WRITE: begin
                data_csb0   = 1'b0;
                data_web0   = 1'b0;
                data_wmask0 = WMASK_ALL;
                state_d     = FILL_DONE;
            end
            FILL_DONE: begin
                // The SRAM committed at the last negedge, so the ack is safe to publish now.
                fill_ack = 1'b1;
                state_d  = FILL_IDLE;
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    always_comb begin
        line_addr_d = line_addr_q;
        if (accept) line_addr_d = fill_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL_IDLE;
            line_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
        end
    end

    icache_fill_line_buf u_line_buf (
        .clk          (clk),
        .rst          (rst),
        .start_i      (buf_start),
        .beat_valid_i (beat_we),
        .beat_data_i  (bmem_rdata),
        .line_o       (fill_line),
        .beat_cnt_o   (beat_cnt),
        .last_beat_o  (last_beat)
    );

    assign bmem_addr  = {line_addr_q, {OFFSET_WIDTH{1'b0}}};
    assign data_addr0 = line_addr_q[OFFSET_WIDTH+SET_IDX_WIDTH-1:OFFSET_WIDTH];
    assign data_din0  = fill_line;

`ifdef ICACHE_FILL_BYPASS_EN
    // byp_sel_q = {beat index, word-in-beat} of the missing instruction.
    logic [CNT_WIDTH:0]      byp_sel_q, byp_sel_d;
    logic                    byp_valid_q, byp_valid_d;
    logic [WORD_WIDTH-1:0]   byp_rdata_q, byp_rdata_d;
    logic                    byp_hit;

    assign byp_hit = beat_we && (beat_cnt == byp_sel_q[CNT_WIDTH:1]);

    always_comb begin
        byp_sel_d   = byp_sel_q;
        byp_valid_d = byp_hit;
        byp_rdata_d = byp_rdata_q;
        if (accept) byp_sel_d = fill_addr[OFFSET_WIDTH-1:2];
        if (byp_hit) begin
            byp_rdata_d = byp_sel_q[0] ? bmem_rdata[BEAT_WIDTH-1:WORD_WIDTH]
                                       : bmem_rdata[WORD_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_sel_q   <= '0;
            byp_valid_q <= 1'b0;
            byp_rdata_q <= '0;
        end else begin
            byp_sel_q   <= byp_sel_d;
            byp_valid_q <= byp_valid_d;
            byp_rdata_q <= byp_rdata_d;
        end
    end

    assign byp_valid = byp_valid_q;
    assign byp_rdata = byp_rdata_q;
`else
    logic unused_byp_bits;
    assign unused_byp_bits = ^{fill_addr[OFFSET_WIDTH-1:0], beat_cnt};
    assign byp_valid = 1'b0;
    assign byp_rdata = '0;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Scoreboard bench for icache_line_fill; bypass checks follow ICACHE_FILL_BYPASS_EN.
module tb_icache_line_fill;

    logic         clk = 1'b0;
    logic         rst;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         fill_ack;
    logic [255:0] fill_line;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         data_csb0;
    logic         data_web0;
    logic [31:0]  data_wmask0;
    logic [3:0]   data_addr0;
    logic [255:0] data_din0;
    logic         byp_valid;
    logic [31:0]  byp_rdata;

    always #5 clk = ~clk;

    icache_line_fill dut (
        .clk         (clk),
        .rst         (rst),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_ack    (fill_ack),
        .fill_line   (fill_line),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .data_csb0   (data_csb0),
        .data_web0   (data_web0),
        .data_wmask0 (data_wmask0),
        .data_addr0  (data_addr0),
        .data_din0   (data_din0),
        .byp_valid   (byp_valid),
        .byp_rdata   (byp_rdata)
    );

    typedef struct packed {
        logic [3:0]   set;
        logic [255:0] line;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_burst_q[$];
    logic [31:0] exp_byp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int burst_cnt = 0;
    int wr_cnt = 0;

    wr_t         mon_wr;
    logic [31:0] mon_word;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a burst, a write, or a bypass word.
    always @(negedge clk) begin
        if (!rst) begin
            if (bmem_read && bmem_ready) begin
                burst_cnt++;
                if (exp_burst_q.size() == 0) check("unexpected_burst", 1'b1, 1'b0);
                else check("burst_addr", bmem_addr, exp_burst_q.pop_front());
            end
            if (!data_csb0) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("wr_set", data_addr0, mon_wr.set);
                    check("wr_din", data_din0, mon_wr.line);
                    check("wr_mask", data_wmask0, 32'hFFFF_FFFF);
                    check("wr_web", data_web0, 1'b0);
                end
            end
            if (fill_ack) ack_cnt++;
            if (byp_valid) begin
                if (exp_byp_q.size() == 0) begin
                    check("unexpected_byp", 1'b1, 1'b0);
                end else begin
                    mon_word = exp_byp_q.pop_front();
                    check("byp_rdata", byp_rdata, mon_word);
                end
            end
        end
    end

    task automatic do_fill(input logic [31:0] addr, input logic [255:0] line,
                           input int rdy_dly, input int gap, input bit hold);
        int  n;
        int  bi;
        bit  got;
        logic [31:0] word;
        bi   = int'(addr[4:3]);
        word = addr[2] ? line[bi*64+32 +: 32] : line[bi*64 +: 32];
        exp_burst_q.push_back(addr & ~32'h1F);
        exp_wr_q.push_back(wr_t'{addr[8:5], line});
`ifdef ICACHE_FILL_BYPASS_EN
        exp_byp_q.push_back(word);
`endif
        fill_addr = addr;
        fill_req  = 1'b1;
        n = 0;
        @(posedge clk); #1; n++;
        if (!hold) fill_req = 1'b0;
        check("req_read", bmem_read, 1'b1);
        repeat (rdy_dly) begin
            @(posedge clk); #1; n++;
            check("read_held", bmem_read, 1'b1);
        end
        bmem_ready = 1'b1;
        @(posedge clk); #1; n++;
        bmem_ready = 1'b0;
        check("read_drop", bmem_read, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bmem_rdata  = line[i*64 +: 64];
            bmem_rvalid = 1'b1;
            @(posedge clk); #1; n++;
            bmem_rvalid = 1'b0;
            bmem_rdata  = '0;
            if (i == bi) begin
`ifdef ICACHE_FILL_BYPASS_EN
                check("byp_pulse", byp_valid, 1'b1);
`else
                check("byp_off_valid", byp_valid, 1'b0);
                check("byp_off_rdata", byp_rdata, 32'h0);
`endif
            end
            if (i < 3) begin
                repeat (gap) begin
                    @(posedge clk); #1; n++;
                end
            end
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (fill_ack) got = 1'b1;
            else begin
                @(posedge clk); #1; n++;
            end
        end
        check("ack_seen", got, 1'b1);
        if (got) begin
            check("ack_latency", n, 7 + rdy_dly + 3*gap);
            check("ack_line", fill_line, line);
        end
    endtask

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L2 = {64'hDEAD_BEEF_0BAD_F00D, 64'hCAFE_BABE_1234_5678,
                                   64'h0F0F_0F0F_F0F0_F0F0, 64'hA5A5_5A5A_C3C3_3C3C};
    localparam logic [255:0] L3 = {64'h8888_7777_6666_5555, 64'h0123_4567_89AB_CDEF,
                                   64'hFEDC_BA98_7654_3210, 64'h1357_9BDF_2468_ACE0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fill_req = 1'b0; fill_addr = '0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_csb0", data_csb0, 1'b1);
        check("rst_web0", data_web0, 1'b1);
        check("rst_read", bmem_read, 1'b0);
        check("rst_ack", fill_ack, 1'b0);
        check("rst_byp", byp_valid, 1'b0);
        check("rst_line", fill_line, 256'h0);

        // Minimum-latency fill.
        do_fill(32'h0000_1234, L1, 0, 0, 1'b0);

        // Slow ready and gapped beats.
        @(posedge clk); #1;
        do_fill(32'h8000_01F8, L2, 3, 2, 1'b0);

        // Reset after two beats aborts the fill.
        @(posedge clk); #1;
        exp_burst_q.push_back(32'h0000_1220);
        fill_addr = 32'h0000_1234;
        fill_req  = 1'b1;
        @(posedge clk); #1;
        fill_req   = 1'b0;
        bmem_ready = 1'b1;
        @(posedge clk); #1;
        bmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bmem_rdata  = L3[i*64 +: 64];
            bmem_rvalid = 1'b1;
            @(posedge clk); #1;
            bmem_rvalid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_read", bmem_read, 1'b0);
        check("abort_csb0", data_csb0, 1'b1);
        check("abort_ack", fill_ack, 1'b0);
        check("abort_line", fill_line, 256'h0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        do_fill(32'h0000_0040, L3, 0, 0, 1'b0);

        // fill_req held high: second fill only after returning to IDLE.
        @(posedge clk); #1;
        do_fill(32'h0000_1234, L2, 0, 0, 1'b1);
        @(posedge clk); #1;
        check("hold_idle_read", bmem_read, 1'b0);
        do_fill(32'h0000_0160, L1, 1, 1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("total_acks", ack_cnt, 5);
        check("total_bursts", burst_cnt, 6);
        check("total_writes", wr_cnt, 5);
        check("burst_q_empty", exp_burst_q.size(), 0);
        check("wr_q_empty", exp_wr_q.size(), 0);
        check("byp_q_empty", exp_byp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
